// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-wide RAM arbiter: FSM states, access sizes,
// owner codes and the bus widths used across the core.
package mem_arbiter_pkg;

    localparam int REG_BUS_W       = 32;
    localparam int INST_ADDR_BUS_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_XFER = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_MEM = 1'b1
    } owner_e;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    // Byte count of an access; the reserved code 11 behaves as a word.
    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        case (size)
            MEM_SIZE_B: size_to_len = 3'd1;
            MEM_SIZE_H: size_to_len = 3'd2;
            default:    size_to_len = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates IF and MEM onto a byte-wide RAM port, sequencing 1/2/4-byte
// little-endian accesses. Define MEM_ARB_RR_EN for round-robin grant on ties.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int RAM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 if_req,
    input  logic [ADDR_W-1:0]    if_addr,
    input  logic                 if_flush,
    output logic [REG_BUS_W-1:0] if_rdata,
    output logic                 if_done,
    input  logic                 mem_req,
    input  logic                 mem_we,
    input  logic [1:0]           mem_size,
    input  logic [ADDR_W-1:0]    mem_addr,
    input  logic [REG_BUS_W-1:0] mem_wdata,
    output logic [REG_BUS_W-1:0] mem_rdata,
    output logic                 mem_done,
    output logic [ADDR_W-1:0]    ram_a,
    output logic [7:0]           ram_dout,
    output logic                 ram_wr,
    input  logic [7:0]           ram_din,
    output logic                 busy
);

    localparam logic [2:0] LAT = 3'(RAM_LAT);

    arb_state_e             state, state_nxt;
    owner_e                 owner;
    logic [ADDR_W-1:0]      base;
    logic [2:0]             len;
    logic [2:0]             cnt;
    logic                   we;
    logic [REG_BUS_W-1:0]   wdata;
    logic [REG_BUS_W-1:0]   data;

    logic                   if_ok, grant_mem, grant_if;
    logic                   abort, issue, last_cyc;
    logic [2:0]             lane;

    assign if_ok = if_req && !if_flush;

`ifdef MEM_ARB_RR_EN
    owner_e last_owner;

    // On a tie, whoever did not own the previous access goes first.
    assign grant_mem = mem_req && (!if_ok || last_owner == OWNER_IF);
    assign grant_if  = if_ok && (!mem_req || last_owner == OWNER_MEM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_owner <= OWNER_IF;
        else if (state == ARB_IDLE && (grant_mem || grant_if))
            last_owner <= grant_mem ? OWNER_MEM : OWNER_IF;
    end
`else
    assign grant_mem = mem_req;
    assign grant_if  = if_ok && !mem_req;
`endif

    assign abort    = if_flush && owner == OWNER_IF && state != ARB_IDLE;
    assign issue    = state == ARB_XFER && cnt <= len && !abort;
    assign last_cyc = cnt == (we ? len : len + LAT);
    assign lane     = cnt - LAT - 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARB_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (grant_mem || grant_if) state_nxt = ARB_XFER;
            ARB_XFER: begin
                if (abort)         state_nxt = ARB_IDLE;
                else if (last_cyc) state_nxt = ARB_DONE;
            end
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner <= OWNER_IF;
            base  <= '0;
            len   <= '0;
            cnt   <= '0;
            we    <= 1'b0;
            wdata <= '0;
            data  <= '0;
        end else if (state == ARB_IDLE) begin
            cnt  <= '0;
            data <= '0;
            if (grant_mem) begin
                owner <= OWNER_MEM;
                base  <= mem_addr;
                len   <= size_to_len(mem_size);
                we    <= mem_we;
                wdata <= mem_wdata;
                cnt   <= 3'd1;
            end else if (grant_if) begin
                owner <= OWNER_IF;
                base  <= if_addr;
                len   <= 3'd4;
                we    <= 1'b0;
                wdata <= '0;
                cnt   <= 3'd1;
            end
        end else if (state == ARB_XFER) begin
            cnt <= cnt + 3'd1;
            // Byte issued RAM_LAT cycles ago lands in its little-endian lane.
            if (!we && cnt > LAT && cnt - LAT <= len) begin
                for (int i = 0; i < 4; i++)
                    if (lane == 3'(i)) data[8*i +: 8] <= ram_din;
            end
        end
    end

    always_comb begin
        ram_a    = '0;
        ram_dout = '0;
        ram_wr   = 1'b0;
        if (issue) begin
            ram_a = base + ADDR_W'(cnt - 3'd1);
            if (we) begin
                ram_wr   = 1'b1;
                ram_dout = 8'(wdata >> {cnt - 3'd1, 3'b000});
            end
        end
    end

    assign if_done   = state == ARB_DONE && owner == OWNER_IF && !if_flush;
    assign mem_done  = state == ARB_DONE && owner == OWNER_MEM;
    assign if_rdata  = if_done  ? data : '0;
    assign mem_rdata = mem_done ? data : '0;
    assign busy      = state != ARB_IDLE;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide RAM port between instruction fetch (IF) and the load/store stage (MEM).
- Sequences each 1/2/4-byte access as consecutive byte cycles and assembles or splits 32-bit words, little-endian.
- Sits between the IF/MEM stages and the external RAM.
- Lets a branch redirect from the decode stage cancel an in-flight fetch.

Parameters:
- ADDR_W, 32, address width of requesters and RAM port
- RAM_LAT, 1, cycles from ram_a driven to matching byte on ram_din (1..2)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held until if_done or if_flush
- if_addr  in  ADDR_W  fetch byte address, always a 4-byte read
- if_flush  in  1  cancel pending/in-flight fetch (branch taken)
- if_rdata  out  32  fetched instruction, valid while if_done=1
- if_done  out  1  one-cycle completion pulse
- mem_req  in  1  load/store request, held until mem_done
- mem_we  in  1  1=store, 0=load
- mem_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- mem_addr  in  ADDR_W  load/store byte address
- mem_wdata  in  32  store data, low bytes used
- mem_rdata  out  32  load data, zero-filled above size, valid while mem_done=1
- mem_done  out  1  one-cycle completion pulse
- ram_a  out  ADDR_W  RAM byte address
- ram_dout  out  8  RAM write byte
- ram_wr  out  1  RAM write strobe
- ram_din  in  8  RAM read byte
- busy  out  1  1 whenever state != IDLE

Behaviour:
- States are IDLE, XFER and DONE, all registered.
- Reset (async, rst_n=0):
  - state=IDLE; all counters 0.
  - All outputs 0 immediately, including ram_wr. A transfer in progress is dropped silently.
- IDLE:
  - Samples requests each cycle.
  - Grant priority is MEM over IF, unless the optional round-robin feature is enabled.
  - An IF request with if_flush=1 in the same cycle is not granted.
  - On grant, latch addr, n (1/2/4 bytes), we, wdata and owner; next state is XFER.
- XFER, with cycle index k=1..:
  - Issue cycles k<=n drive ram_a=base+(k-1).
  - Stores: ram_wr=1 and ram_dout=wdata[8(k-1)+:8].
  - Loads: byte for issue k is captured at the end of cycle k+RAM_LAT into byte lane k-1.
  - Outside issue cycles: ram_a=0, ram_wr=0.
  - Store leaves after cycle n. Load leaves after cycle n+RAM_LAT.
  - Next state is DONE.
- DONE:
  - Exactly one cycle; the owner's done=1 with its rdata. Next state is IDLE.
  - The requester must drop req by the following IDLE cycle; a held req is re-granted as a new access.
- Latency from grant cycle 0:
  - Load with RAM_LAT=1: done in cycle n+2 (word = cycle 6).
  - Store: done in cycle n+1 (word = cycle 5).
- Flush:
  - if_flush=1 during XFER or DONE with owner=IF: abort, go to IDLE next edge, suppress if_done, stop issuing addresses.
  - Late bytes are ignored.
  - if_flush never affects a MEM-owned transfer.
- Addresses wrap modulo 2^ADDR_W; no alignment requirement.
- Simultaneous if_req and mem_req: one is granted; the other waits, with no loss as long as its req is held.
- Request inputs are sampled only in IDLE; changes during XFER are ignored.

Optional Feature:
- MEM_ARB_RR_EN defined:
  - Round-robin between IF and MEM. A 1-bit last-owner register (reset = IF) gives priority to the non-last owner on a tie.
- Undefined: fixed MEM>IF priority. An IF request can starve while MEM requests back-to-back.

Decomposition:
- Shared defines header holds:
  - state encodings (ARB_IDLE/ARB_XFER/ARB_DONE)
  - size codes (MEM_SIZE_B/H/W)
  - owner codes (OWNER_IF/OWNER_MEM)
  - existing `RegBus / `InstAddrBus widths
- Single module; no sub-module is natural (byte lane packing is a few lines).

Test Plan:
- Word fetch:
  - Stimulus: RAM[0x100..0x103]=13,05,00,00; if_req at 0x100.
  - Required: ram_a 0x100..0x103 in cycles 1-4; if_done in cycle 6; if_rdata=0x00000513.
- Store half:
  - Stimulus: mem_req we=1, size=01, addr=0x200, wdata=0xDEADBEEF.
  - Required: ram_wr with 0xEF at 0x200, then 0xBE at 0x201; mem_done in cycle 3; RAM[0x202] unchanged.
- Load byte:
  - Stimulus: RAM[0x203]=0x80.
  - Required: mem_rdata=0x00000080 (zero-filled); mem_done in cycle 3.
- Contention:
  - Stimulus: if_req and mem_req asserted together.
  - Required (fixed priority): MEM served first, IF done after MEM done+1+6.
  - Required with MEM_ARB_RR_EN and back-to-back requests: grants alternate MEM, IF, MEM, IF.
- Flush mid-fetch:
  - Stimulus: if_flush in XFER cycle 2.
  - Required: no if_done; busy=0 next cycle; no further ram_a; a new if_req gets a fresh 4-byte fetch.
- Reset mid-store:
  - Stimulus: rst_n low during XFER cycle 2 of a word store.
  - Required: ram_wr=0 same cycle; all outputs 0; after release, state IDLE and a new request completes normally.
